booth_mult_seq: RTL and testbench
=================================

// Module: booth_mult_seq
// PURPOSE
//   Parametrised sequential Booth multiplier; next generation of the fixed 8-bit boothMult.
//   Generic operand width, per-operation signed/unsigned mode, Busy/Finish handshake,
//   clean 2*WIDTH product (no guard bits exposed). Sits beside the datapath as a
//   multi-cycle arithmetic unit started by a one-cycle Start pulse.
// PARAMETERS
//   WIDTH   8   operand width in bits; must be even and >= 4
// PORTS
//   clk          in   1          rising-edge clock
//   Resetn       in   1          asynchronous reset, ACTIVE-HIGH (1 = reset)
//   Start        in   1          request; sampled on rising clk edge
//   Signed_mode  in   1          1 = two's-complement operands, 0 = unsigned; sampled with Start
//   Mplier       in   WIDTH      multiplier; sampled with Start
//   Mcand        in   WIDTH      multiplicand; sampled with Start
//   Busy         out  1          high while an operation is in progress
//   Finish       out  1          one-cycle pulse: Product valid
//   Product      out  2*WIDTH    result; held stable until next accepted Start
// BEHAVIOUR
//   Reset (Resetn=1, async, any time incl. mid-operation): state=IDLE, Busy=0, Finish=0,
//     Product=0, internal accumulator/counter cleared; operation in flight discarded.
//   States: IDLE -> RUN -> DONE -> IDLE.
//     IDLE: Start=1 at edge t0 -> latch operands + mode, extend to E bits
//       (sign-extend if Signed_mode, zero-extend otherwise), clear accumulator, Booth
//       bit q(-1)=0, counter=N_IT; go RUN. Busy=1 from t0.
//     RUN : one Booth step per edge; counter decrements; on the step with counter=1 go DONE.
//     DONE: Finish=1, Busy=0 for exactly one cycle; Product register written on the edge
//       entering DONE. Next edge -> IDLE, or straight back to RUN if Start=1 (back-to-back).
//   Start while Busy=1 (RUN) is ignored; inputs may change freely while Busy.
//   Latency: Finish high in cycle after edge t0+N_IT (radix-2: N_IT=WIDTH+1, E=WIDTH+1).
//   Radix-2 step: examine {q0,q(-1)}: 01 -> acc+=M, 10 -> acc-=M, 00/11 -> none;
//     then arithmetic right shift of {acc,Q,q(-1)} by 1. acc is E+1 bits (no overflow).
//   Product = low 2*WIDTH bits of {acc,Q} after last step; exact for all inputs in both
//     modes (e.g. unsigned 255*255, signed -128*-128 fit in 16 bits).
//   Signed_mode only affects extension; it is not re-sampled during RUN.
// CONFIGURATION
//   BOOTH_RADIX4_EN defined: modified Booth radix-4 recoding; examine {q1,q0,q(-1)},
//     partial product in {0,+-M,+-2M}, arithmetic shift by 2 per step; E=WIDTH+2,
//     N_IT=WIDTH/2+1 (WIDTH=8 -> 5 cycles). Same ports, same Product values.
//   Undefined (default): radix-2 as above (WIDTH=8 -> 9 cycles).
// TESTING
//   1 WIDTH=8 signed, 127*127, Start pulse -> Finish after 9 cycles, Product=16'h3F01 (16129).
//   2 signed -128*-128 -> 16'h4000; signed -128*127 -> 16'hC080 (-16256); 0*x -> 0.
//   3 unsigned 255*255 -> 16'hFE01; same bits signed (-1*-1) -> 16'h0001.
//   4 Start re-pulsed with new operands at cycle 3 of RUN -> ignored, first result
//     returned on schedule; Start held high in DONE -> second op starts, no IDLE cycle.
//   5 Resetn=1 asserted mid-RUN between clock edges -> Busy/Finish/Product=0 immediately;
//     after release, fresh Start 5*-3 -> 16'hFFF1.
//   6 BOOTH_RADIX4_EN defined: repeat 1-3 -> identical Products, Finish after 5 cycles;
//     random 1000 ops both modes vs. behavioural a*b, WIDTH=8 and WIDTH=16.

Source files
------------

// File: rtl/booth_mult_seq.sv
// Sequential Booth multiplier: radix-2 by default, modified Booth radix-4 when BOOTH_RADIX4_EN is defined.
// Start/Busy/Finish handshake, exact 2*WIDTH product in both signed and unsigned mode.
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               Resetn,
  input  logic               Start,
  input  logic               Signed_mode,
  input  logic [WIDTH-1:0]   Mplier,
  input  logic [WIDTH-1:0]   Mcand,
  output logic               Busy,
  output logic               Finish,
  output logic [2*WIDTH-1:0] Product
);

`ifdef BOOTH_RADIX4_EN
  localparam int E     = WIDTH + 2;
  localparam int SHIFT = 2;
  localparam int N_IT  = WIDTH / 2 + 1;
  localparam int AW    = E + 2;
`else
  localparam int E     = WIDTH + 1;
  localparam int SHIFT = 1;
  localparam int N_IT  = WIDTH + 1;
  localparam int AW    = E + 1;
`endif
  localparam int CW = $clog2(N_IT + 1);
  localparam int SW = AW + E + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [AW-1:0] acc;
  logic [E-1:0]  q;
  logic [E-1:0]  m;
  logic          qm1;
  logic [CW-1:0] cnt;

  logic [E-1:0]  mplier_ext;
  logic [E-1:0]  mcand_ext;
  logic [AW-1:0] mx;
  logic [AW-1:0] pp;
  logic [AW-1:0] sum;
  logic [SW-1:0] shifted;
  logic [AW-1:0] acc_nxt;
  logic [E-1:0]  q_nxt;
  logic          qm1_nxt;

  // Unsigned operands gain a zero sign bit so the Booth core always works on signed values.
  assign mplier_ext = {{(E-WIDTH){Signed_mode & Mplier[WIDTH-1]}}, Mplier};
  assign mcand_ext  = {{(E-WIDTH){Signed_mode & Mcand[WIDTH-1]}}, Mcand};
  assign mx         = {{(AW-E){m[E-1]}}, m};

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    pp = '0;
`ifdef BOOTH_RADIX4_EN
    case ({q[1:0], qm1})
      3'b001, 3'b010: pp = mx;
      3'b011:         pp = mx << 1;
      3'b100:         pp = -(mx << 1);
      3'b101, 3'b110: pp = -mx;
      default:        pp = '0;
    endcase
`else
    case ({q[0], qm1})
      2'b01:   pp = mx;
      2'b10:   pp = -mx;
      default: pp = '0;
    endcase
`endif
    sum     = acc + pp;
    shifted = $signed({sum, q, qm1}) >>> SHIFT;
    {acc_nxt, q_nxt, qm1_nxt} = shifted;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: all datapath registers are reset too, so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or posedge Resetn) begin
    if (Resetn) begin
      state   <= IDLE;
      Busy    <= 1'b0;
      Finish  <= 1'b0;
      Product <= '0;
      acc     <= '0;
      q       <= '0;
      m       <= '0;
      qm1     <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          Finish <= 1'b0;
          if (Start) begin
            acc   <= '0;
            q     <= mplier_ext;
            m     <= mcand_ext;
            qm1   <= 1'b0;
            cnt   <= CW'(N_IT);
            Busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          q   <= q_nxt;
          qm1 <= qm1_nxt;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            Product <= shifted[2*WIDTH:1];
            Busy    <= 1'b0;
            Finish  <= 1'b1;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq (WIDTH=8): products, latency, handshake, Start masking, async reset.
module tb_booth_mult_seq;
  localparam int WIDTH = 8;
`ifdef BOOTH_RADIX4_EN
  localparam int N_IT = WIDTH / 2 + 1;
`else
  localparam int N_IT = WIDTH + 1;
`endif

  logic              clk = 1'b0;
  logic              Resetn = 1'b1;
  logic              Start = 1'b0;
  logic              Signed_mode = 1'b0;
  logic [WIDTH-1:0]  Mplier = '0;
  logic [WIDTH-1:0]  Mcand = '0;
  logic              Busy;
  logic              Finish;
  logic [2*WIDTH-1:0] Product;

  int vectors = 0;
  int miscompares = 0;
  int cyc;

  booth_mult_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .Resetn(Resetn), .Start(Start), .Signed_mode(Signed_mode),
    .Mplier(Mplier), .Mcand(Mcand), .Busy(Busy), .Finish(Finish), .Product(Product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_finish(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (!Finish && cycles < 100);
  endtask

  task automatic run_op(input string tag, input logic s, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [2*WIDTH-1:0] exp);
    int c;
    @(negedge clk);
    Start = 1'b1; Signed_mode = s; Mplier = a; Mcand = b;
    @(posedge clk); #1;
    Start = 1'b0;
    check({tag, "_busy"}, Busy, 1);
    Mplier = ~a; Mcand = ~b; Signed_mode = ~s;
    wait_finish(c);
    check({tag, "_latency"}, c, N_IT);
    check({tag, "_product"}, Product, exp);
    check({tag, "_busy_done"}, Busy, 0);
    @(posedge clk); #1;
    check({tag, "_finish_pulse"}, Finish, 0);
    check({tag, "_held"}, Product, exp);
  endtask

  initial begin
    #12;
    check("reset_busy", Busy, 0);
    check("reset_finish", Finish, 0);
    check("reset_product", Product, 0);
    @(negedge clk);
    Resetn = 1'b0;

    run_op("s_127x127",   1'b1, 8'h7F, 8'h7F, 16'h3F01);
    run_op("s_m128xm128", 1'b1, 8'h80, 8'h80, 16'h4000);
    run_op("s_m128x127",  1'b1, 8'h80, 8'h7F, 16'hC080);
    run_op("s_0x5a",      1'b1, 8'h00, 8'h5A, 16'h0000);
    run_op("u_255x255",   1'b0, 8'hFF, 8'hFF, 16'hFE01);
    run_op("s_m1xm1",     1'b1, 8'hFF, 8'hFF, 16'h0001);
    run_op("u_128x2",     1'b0, 8'h80, 8'h02, 16'h0100);
    run_op("s_m128x2",    1'b1, 8'h80, 8'h02, 16'hFF00);

    // Start re-pulsed mid-RUN must be ignored; Start held in DONE chains the next operation.
    @(negedge clk);
    Start = 1'b1; Signed_mode = 1'b1; Mplier = 8'd12; Mcand = 8'd10;
    @(posedge clk); #1;
    Start = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 3) begin
        Start = 1'b1; Signed_mode = 1'b0; Mplier = 8'd3; Mcand = 8'd3;
      end else begin
        Start = 1'b0;
      end
    end while (!Finish && cyc < 100);
    check("ignore_latency", cyc, N_IT);
    check("ignore_product", Product, 16'h0078);
    Start = 1'b1; Signed_mode = 1'b0; Mplier = 8'd200; Mcand = 8'd3;
    @(posedge clk); #1;
    Start = 1'b0;
    check("b2b_busy", Busy, 1);
    check("b2b_finish_low", Finish, 0);
    check("b2b_product_held", Product, 16'h0078);
    wait_finish(cyc);
    check("b2b_latency", cyc, N_IT);
    check("b2b_product", Product, 16'h0258);
    @(posedge clk); #1;
    check("b2b_idle_busy", Busy, 0);
    check("b2b_idle_finish", Finish, 0);

    // Asynchronous reset between edges in the middle of an operation.
    @(negedge clk);
    Start = 1'b1; Signed_mode = 1'b1; Mplier = 8'd100; Mcand = 8'd100;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (2) @(posedge clk);
    #3 Resetn = 1'b1;
    #1;
    check("arst_busy", Busy, 0);
    check("arst_finish", Finish, 0);
    check("arst_product", Product, 0);
    @(posedge clk); #1;
    check("arst_hold_busy", Busy, 0);
    @(negedge clk);
    Resetn = 1'b0;
    run_op("s_5xm3", 1'b1, 8'h05, 8'hFD, 16'hFFF1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
